// File: rtl/seg_scan_decoder.sv
// Recovers the digits shown on a multiplexed active-low 7-segment display by sampling its cathode/anode lines.
// Optional macro SEG_ERR_COUNT_EN enables the saturating ERR_COUNT error counter (tied to 0 otherwise).
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned NUM_DIGITS    = 4
) (
  input  logic                    CLK100MHZ,
  input  logic                    RESET_BTN,
  input  logic [7:0]              SevenSegment,
  input  logic [7:0]              SegmentDrivers,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [NUM_DIGITS-1:0]   DP_OUT,
  output logic                    FRAME_VALID,
  output logic                    PATTERN_ERR,
  output logic [7:0]              ERR_COUNT
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t state, next_state;

  logic [7:0]       seg_q, an_q, seg_prev, an_prev;
  logic [CNT_W-1:0] stab_cnt;
  logic [DIG_W-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0] shadow_dp, cap_mask;

  logic       same_c, capture_c;
  logic [7:0] an_low_c;
  logic [2:0] an_idx_c;
  logic       an_blank_c, an_onehot_c, an_ok_c;
  logic [3:0] seg_nib_c;
  logic       seg_bad_c;
  logic       cap_en_c, an_err_c, seg_err_c, err_evt_c;
  logic       frame_full_c;

  assign same_c       = (seg_q == seg_prev) && (an_q == an_prev);
  assign frame_full_c = &cap_mask;

  // Input sampling, one-sample history and stability counter
  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_BTN) begin
      seg_q    <= 8'd0;
      an_q     <= 8'd0;
      seg_prev <= 8'd0;
      an_prev  <= 8'd0;
      stab_cnt <= '0;
    end else begin
      seg_q    <= SevenSegment;
      an_q     <= SegmentDrivers;
      seg_prev <= seg_q;
      an_prev  <= an_q;
      if (!same_c)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_BTN) state <= S_WAIT;
    else            state <= next_state;
  end

  // Dwell FSM; a change seen during CAPTURE restarts counting instead of waiting in HOLD
  always_comb begin
    next_state = state;
    capture_c  = 1'b0;
    case (state)
      S_WAIT: begin
        if (same_c && (stab_cnt == CNT_MAX)) next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture_c  = 1'b1;
        next_state = same_c ? S_HOLD : S_WAIT;
      end
      S_HOLD: begin
        if (!same_c) next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

  // Anode and segment decode of the stable sample (held in the history register during CAPTURE)
  always_comb begin
    an_low_c    = ~an_prev;
    an_blank_c  = (an_prev == 8'hFF);
    an_onehot_c = (an_low_c != 8'd0) && ((an_low_c & (an_low_c - 8'd1)) == 8'd0);
    an_idx_c    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low_c[i]) an_idx_c = 3'(i);
    end
    an_ok_c = an_onehot_c && (32'(an_idx_c) < NUM_DIGITS);

    seg_bad_c = 1'b0;
    case (seg_prev[6:0])
      7'h40:   seg_nib_c = 4'h0;
      7'h79:   seg_nib_c = 4'h1;
      7'h24:   seg_nib_c = 4'h2;
      7'h30:   seg_nib_c = 4'h3;
      7'h19:   seg_nib_c = 4'h4;
      7'h12:   seg_nib_c = 4'h5;
      7'h02:   seg_nib_c = 4'h6;
      7'h78:   seg_nib_c = 4'h7;
      7'h00:   seg_nib_c = 4'h8;
      7'h10:   seg_nib_c = 4'h9;
      7'h7F:   seg_nib_c = 4'hF;
      default: begin
        seg_nib_c = 4'hE;
        seg_bad_c = 1'b1;
      end
    endcase

    cap_en_c  = capture_c && !an_blank_c && an_ok_c;
    an_err_c  = capture_c && !an_blank_c && !an_ok_c;
    seg_err_c = cap_en_c && seg_bad_c;
    err_evt_c = an_err_c || seg_err_c;
  end

  // Shadow slots, capture mask and frame publication
  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_BTN) begin
      shadow_dig  <= '0;
      shadow_dp   <= '0;
      cap_mask    <= '0;
      DIGITS      <= '0;
      DP_OUT      <= '0;
      FRAME_VALID <= 1'b0;
      PATTERN_ERR <= 1'b0;
    end else begin
      FRAME_VALID <= frame_full_c;
      if (frame_full_c) begin
        DIGITS <= shadow_dig;
        DP_OUT <= shadow_dp;
      end
      for (int p = 0; p < int'(NUM_DIGITS); p++) begin
        if (cap_en_c && (an_idx_c == 3'(p))) begin
          shadow_dig[4*p +: 4] <= seg_nib_c;
          shadow_dp[p]         <= ~seg_prev[7];
          cap_mask[p]          <= 1'b1;
        end else if (frame_full_c) begin
          cap_mask[p] <= 1'b0;
        end
      end
      if (err_evt_c) PATTERN_ERR <= 1'b1;
    end
  end

`ifdef SEG_ERR_COUNT_EN
  // Saturating count of segment and anode error events
  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_BTN)
      ERR_COUNT <= 8'd0;
    else if (err_evt_c && (ERR_COUNT != 8'hFF))
      ERR_COUNT <= ERR_COUNT + 8'd1;
  end
`else
  assign ERR_COUNT = 8'd0;
`endif

endmodule
